counter_prog: RTL and testbench
===============================

Name: counter_prog

Overview:
Parametrised successor to the team's basic up/down counter, adding a programmable upper limit, a programmable step size, and three overflow modes (wrap, saturate, one-shot). It also adds a terminal-count pulse and a sticky one-shot done flag. The block serves as a general timer and sequencer primitive for control logic elsewhere in the design. All outputs are registered.

Parameters:
WIDTH, 4, bit width of count, data and lim.
STEP_W, 2, bit width of step; constraint 1 <= STEP_W <= WIDTH.

Ports:
clk  in  1  clock; all state updates on the rising edge.
rst  in  1  reset, synchronous, active-high.
en  in  1  count enable.
dn  in  1  direction: 0 = up, 1 = down.
load  in  1  synchronous load of data.
data  in  WIDTH  load value.
step  in  STEP_W  increment/decrement magnitude.
lim  in  WIDTH  inclusive upper bound; count range is 0..lim.
mode  in  2  0 = WRAP, 1 = SAT, 2 = ONESHOT, 3 = reserved, behaves as WRAP.
count  out  WIDTH  current count.
tc  out  1  terminal-count pulse, high for 1 cycle after the boundary event.
done  out  1  sticky flag, ONESHOT mode only.

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high (rst).
- Priority per edge: rst > load > (en & ~done) > hold.
- Reset: count=0, tc=0, done=0. Reset mid-count or with load=1 still forces these values.
- Load: count = min(data, lim), tc=0, done=0. Load is not gated by en.
- Hold (en=0, or done=1, or step==0): count unchanged, tc=0.
- Latency: inputs sampled at edge N; count, tc and done are valid after edge N. No combinational path from inputs to outputs.
- Up-count arithmetic: n = count + step, computed in WIDTH+1 bits; ovf = (n > lim).
- WRAP, up: if ovf, count=0 and tc=1. Otherwise count=n and tc=0.
- SAT, up: if ovf or n==lim, count=lim and tc = (old count != lim). Otherwise count=n.
- ONESHOT, up: if ovf or n==lim, count=lim, tc=1, done=1. Otherwise count=n.
- Down-count arithmetic: unf = (step > count); n = count - step.
- WRAP, down: if unf, count=lim and tc=1. Otherwise count=n.
- SAT, down: if unf or n==0, count=0 and tc = (old count != 0). Otherwise count=n.
- ONESHOT, down: if unf or n==0, count=0, tc=1, done=1. Otherwise count=n.
- done: once set, it freezes counting (en ignored) until load or rst. mode has no effect on a frozen counter.
- Out-of-range count: count > lim can occur after lim is lowered. An up step then takes the ovf path; a down step uses the normal arithmetic.
- lim==0: every up or down step is an immediate boundary event.
- Live inputs: dn, mode, step and lim may change on any cycle and take effect on the next enabled edge.

Decomposition:
- Shared package counter_pkg: mode encodings MODE_WRAP=2'd0, MODE_SAT=2'd1, MODE_ONESHOT=2'd2, MODE_RSVD=2'd3.
- Optional combinational sub-module counter_prog_next: computes next count, tc and done from the current state and inputs. The top level holds only the registers and the priority mux.

Test Plan:
(All scenarios: WIDTH=4, STEP_W=2, lim=9.)
1. rst=1 for one edge while en=1 and load=1 -> count=0, tc=0, done=0.
2. WRAP, up, step=1, from 0 -> count 1..9, then 0 with a single tc pulse. Load 7, step=3 -> 10>9, so count=0 with tc=1.
3. WRAP, down, load 2, step=1 -> count 1, 0, then 9 with tc=1, then 8 with tc=0.
4. SAT, up, step=3, from 0 -> count 3, 6, 9 (tc=1 on 9), then 9, 9 with tc=0.
5. ONESHOT, down, load 5, step=2 -> count 3, 1, then 0 with tc=1 and done=1. Count stays 0 with en=1 held. Load 7 -> count=7, done=0, counting resumes.
6. Limit, load and step edge cases:
   - load=1 with en=1 and data=12 -> count=9 (clamped; load wins).
   - lim lowered to 4 with count=9, WRAP, up -> count=0, tc=1.
   - step=0 -> count holds, tc=0.

Source files
------------

// File: rtl/counter_pkg.sv
// Shared definitions for the programmable counter: overflow mode encodings.
package counter_pkg;

   typedef enum logic [1:0] {
      MODE_WRAP    = 2'd0,
      MODE_SAT     = 2'd1,
      MODE_ONESHOT = 2'd2,
      MODE_RSVD    = 2'd3
   } mode_t;

endpackage

// File: rtl/counter_prog_next.sv
// Combinational next-state logic for counter_prog: one enabled step of the
// count in the selected direction and overflow mode, with tc/done side effects.
module counter_prog_next
   import counter_pkg::*;
#(
   parameter int WIDTH  = 4,
   parameter int STEP_W = 2
) (
   input  logic [WIDTH-1:0]  count,
   input  logic              dn,
   input  logic [STEP_W-1:0] step,
   input  logic [WIDTH-1:0]  lim,
   input  logic [1:0]        mode,
   output logic [WIDTH-1:0]  next_count,
   output logic              next_tc,
   output logic              next_done
);

   logic [WIDTH:0]   step_x;
   logic [WIDTH:0]   count_x;
   logic [WIDTH:0]   lim_x;
   logic [WIDTH:0]   up_sum;
   logic [WIDTH-1:0] down_diff;
   logic             ovf;
   logic             unf;
   logic             up_edge;
   logic             down_edge;

   // One spare bit keeps the up-step carry visible so ovf is exact.
   assign step_x    = {{(WIDTH + 1 - STEP_W){1'b0}}, step};
   assign count_x   = {1'b0, count};
   assign lim_x     = {1'b0, lim};
   assign up_sum    = count_x + step_x;
   assign ovf       = (up_sum > lim_x);
   assign up_edge   = ovf || (up_sum == lim_x);
   assign unf       = (step_x > count_x);
   assign down_diff = count - step_x[WIDTH-1:0];
   assign down_edge = unf || (down_diff == '0);

   always_comb begin
      next_count = count;
      next_tc    = 1'b0;
      next_done  = 1'b0;
      if (!dn) begin
         case (mode_t'(mode))
            MODE_SAT: begin
               if (up_edge) begin
                  next_count = lim;
                  next_tc    = (count != lim);
               end else begin
                  next_count = up_sum[WIDTH-1:0];
               end
            end
            MODE_ONESHOT: begin
               if (up_edge) begin
                  next_count = lim;
                  next_tc    = 1'b1;
                  next_done  = 1'b1;
               end else begin
                  next_count = up_sum[WIDTH-1:0];
               end
            end
            default: begin
               if (ovf) begin
                  next_count = '0;
                  next_tc    = 1'b1;
               end else begin
                  next_count = up_sum[WIDTH-1:0];
               end
            end
         endcase
      end else begin
         // Down steps ignore lim except as the WRAP reload value.
         case (mode_t'(mode))
            MODE_SAT: begin
               if (down_edge) begin
                  next_count = '0;
                  next_tc    = (count != '0);
               end else begin
                  next_count = down_diff;
               end
            end
            MODE_ONESHOT: begin
               if (down_edge) begin
                  next_count = '0;
                  next_tc    = 1'b1;
                  next_done  = 1'b1;
               end else begin
                  next_count = down_diff;
               end
            end
            default: begin
               if (unf) begin
                  next_count = lim;
                  next_tc    = 1'b1;
               end else begin
                  next_count = down_diff;
               end
            end
         endcase
      end
   end

endmodule

// File: rtl/counter_prog.sv
// Programmable up/down counter with limit, step and wrap/saturate/one-shot
// modes. Holds the registers and the reset > load > count > hold priority.
module counter_prog
   import counter_pkg::*;
#(
   parameter int WIDTH  = 4,
   parameter int STEP_W = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic              dn,
   input  logic              load,
   input  logic [WIDTH-1:0]  data,
   input  logic [STEP_W-1:0] step,
   input  logic [WIDTH-1:0]  lim,
   input  logic [1:0]        mode,
   output logic [WIDTH-1:0]  count,
   output logic              tc,
   output logic              done
);

   logic [WIDTH-1:0] next_count;
   logic             next_tc;
   logic             next_done;
   logic             advance;

   counter_prog_next #(
      .WIDTH  (WIDTH),
      .STEP_W (STEP_W)
   ) u_next (
      .count      (count),
      .dn         (dn),
      .step       (step),
      .lim        (lim),
      .mode       (mode),
      .next_count (next_count),
      .next_tc    (next_tc),
      .next_done  (next_done)
   );

   // A zero step is treated as a hold so it can never fire a boundary event.
   assign advance = en && !done && (step != '0);

   always_ff @(posedge clk) begin
      if (rst) begin
         count <= '0;
         tc    <= 1'b0;
         done  <= 1'b0;
      end else if (load) begin
         count <= (data > lim) ? lim : data;
         tc    <= 1'b0;
         done  <= 1'b0;
      end else if (advance) begin
         count <= next_count;
         tc    <= next_tc;
         done  <= next_done;
      end else begin
         tc    <= 1'b0;
      end
   end

endmodule

// File: tb/tb_counter_prog.sv
// Self-checking bench for counter_prog: directed scenarios with literal
// expectations, then randomized traffic checked every cycle against a model.
module tb_counter_prog;

   logic       clk;
   logic       rst;
   logic       en;
   logic       dn;
   logic       load;
   logic [3:0] data;
   logic [1:0] step;
   logic [3:0] lim;
   logic [1:0] mode;
   logic [3:0] count;
   logic       tc;
   logic       done;

   int compared;
   int mismatched;
   int m_count;
   int m_tc;
   int m_done;
   bit checking;

   counter_prog #(
      .WIDTH  (4),
      .STEP_W (2)
   ) dut (
      .clk   (clk),
      .rst   (rst),
      .en    (en),
      .dn    (dn),
      .load  (load),
      .data  (data),
      .step  (step),
      .lim   (lim),
      .mode  (mode),
      .count (count),
      .tc    (tc),
      .done  (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model in plain integer arithmetic; negative results mean underflow.
   always @(posedge clk) begin
      int n;
      int l;
      l = int'(lim);
      if (rst) begin
         m_count = 0;
         m_tc    = 0;
         m_done  = 0;
      end else if (load) begin
         m_count = (int'(data) > l) ? l : int'(data);
         m_tc    = 0;
         m_done  = 0;
      end else if (en && m_done == 0 && step != 0) begin
         if (!dn) begin
            n = m_count + int'(step);
            if (mode == 2'd1) begin
               if (n >= l) begin
                  m_tc    = (m_count != l) ? 1 : 0;
                  m_count = l;
               end else begin
                  m_tc    = 0;
                  m_count = n;
               end
            end else if (mode == 2'd2) begin
               if (n >= l) begin
                  m_count = l;
                  m_tc    = 1;
                  m_done  = 1;
               end else begin
                  m_tc    = 0;
                  m_count = n;
               end
            end else begin
               m_tc    = (n > l) ? 1 : 0;
               m_count = (n > l) ? 0 : n;
            end
         end else begin
            n = m_count - int'(step);
            if (mode == 2'd1) begin
               if (n <= 0) begin
                  m_tc    = (m_count != 0) ? 1 : 0;
                  m_count = 0;
               end else begin
                  m_tc    = 0;
                  m_count = n;
               end
            end else if (mode == 2'd2) begin
               if (n <= 0) begin
                  m_count = 0;
                  m_tc    = 1;
                  m_done  = 1;
               end else begin
                  m_tc    = 0;
                  m_count = n;
               end
            end else begin
               m_tc    = (n < 0) ? 1 : 0;
               m_count = (n < 0) ? l : n;
            end
         end
      end else begin
         m_tc = 0;
      end
   end

   // Every-cycle comparison, sampled on the falling edge.
   always @(negedge clk) begin
      if (checking) begin
         compared++;
         if (count !== 4'(m_count) || tc !== 1'(m_tc) || done !== 1'(m_done)) begin
            mismatched++;
            $display("[TB] FAIL cycle_cmp t=%0t: dut count=%0d tc=%b done=%b, model count=%0d tc=%0d done=%0d",
                     $time, count, tc, done, m_count, m_tc, m_done);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_stimulus(input logic l_load, input logic [3:0] l_data,
                                 input logic l_en, input logic l_dn,
                                 input logic [1:0] l_step, input logic [1:0] l_mode);
      load = l_load;
      data = l_data;
      en   = l_en;
      dn   = l_dn;
      step = l_step;
      mode = l_mode;
      tick();
   endtask

   task automatic check_output(input string name, input int c, input int t, input int d);
      compared++;
      if (count !== 4'(c) || tc !== 1'(t) || done !== 1'(d)) begin
         mismatched++;
         $display("[TB] FAIL %s: dut count=%0d tc=%b done=%b, expected count=%0d tc=%0d done=%0d",
                  name, count, tc, done, c, t, d);
      end
      compared++;
      if (m_count != c || m_tc != t || m_done != d) begin
         mismatched++;
         $display("[TB] FAIL %s_model: model count=%0d tc=%0d done=%0d, expected count=%0d tc=%0d done=%0d",
                  name, m_count, m_tc, m_done, c, t, d);
      end
   endtask

   initial begin
      compared   = 0;
      mismatched = 0;
      checking   = 1'b0;
      m_count    = 0;
      m_tc       = 0;
      m_done     = 0;
      lim        = 4'd9;

      // Reset wins over load and enable.
      rst = 1'b1;
      apply_stimulus(1'b1, 4'd5, 1'b1, 1'b0, 2'd1, 2'd0);
      checking = 1'b1;
      check_output("reset", 0, 0, 0);
      rst = 1'b0;

      // WRAP up by 1 through the full range.
      for (int i = 1; i <= 9; i++) begin
         apply_stimulus(1'b0, 4'd0, 1'b1, 1'b0, 2'd1, 2'd0);
         check_output($sformatf("wrap_up_%0d", i), i, 0, 0);
      end
      apply_stimulus(1'b0, 4'd0, 1'b1, 1'b0, 2'd1, 2'd0);
      check_output("wrap_up_roll", 0, 1, 0);
      apply_stimulus(1'b1, 4'd7, 1'b1, 1'b0, 2'd3, 2'd0);
      check_output("wrap_load7", 7, 0, 0);
      apply_stimulus(1'b0, 4'd0, 1'b1, 1'b0, 2'd3, 2'd0);
      check_output("wrap_up_ovf", 0, 1, 0);

      // WRAP down through zero.
      apply_stimulus(1'b1, 4'd2, 1'b1, 1'b1, 2'd1, 2'd0);
      check_output("wrap_dn_load2", 2, 0, 0);
      apply_stimulus(1'b0, 4'd0, 1'b1, 1'b1, 2'd1, 2'd0);
      check_output("wrap_dn_1", 1, 0, 0);
      apply_stimulus(1'b0, 4'd0, 1'b1, 1'b1, 2'd1, 2'd0);
      check_output("wrap_dn_0", 0, 0, 0);
      apply_stimulus(1'b0, 4'd0, 1'b1, 1'b1, 2'd1, 2'd0);
      check_output("wrap_dn_roll", 9, 1, 0);
      apply_stimulus(1'b0, 4'd0, 1'b1, 1'b1, 2'd1, 2'd0);
      check_output("wrap_dn_8", 8, 0, 0);

      // SAT up by 3.
      apply_stimulus(1'b1, 4'd0, 1'b0, 1'b0, 2'd3, 2'd1);
      check_output("sat_load0", 0, 0, 0);
      apply_stimulus(1'b0, 4'd0, 1'b1, 1'b0, 2'd3, 2'd1);
      check_output("sat_3", 3, 0, 0);
      apply_stimulus(1'b0, 4'd0, 1'b1, 1'b0, 2'd3, 2'd1);
      check_output("sat_6", 6, 0, 0);
      apply_stimulus(1'b0, 4'd0, 1'b1, 1'b0, 2'd3, 2'd1);
      check_output("sat_9", 9, 1, 0);
      apply_stimulus(1'b0, 4'd0, 1'b1, 1'b0, 2'd3, 2'd1);
      check_output("sat_hold_a", 9, 0, 0);
      apply_stimulus(1'b0, 4'd0, 1'b1, 1'b0, 2'd3, 2'd1);
      check_output("sat_hold_b", 9, 0, 0);

      // ONESHOT down by 2, freeze, then resume after load.
      apply_stimulus(1'b1, 4'd5, 1'b1, 1'b1, 2'd2, 2'd2);
      check_output("os_load5", 5, 0, 0);
      apply_stimulus(1'b0, 4'd0, 1'b1, 1'b1, 2'd2, 2'd2);
      check_output("os_3", 3, 0, 0);
      apply_stimulus(1'b0, 4'd0, 1'b1, 1'b1, 2'd2, 2'd2);
      check_output("os_1", 1, 0, 0);
      apply_stimulus(1'b0, 4'd0, 1'b1, 1'b1, 2'd2, 2'd2);
      check_output("os_done", 0, 1, 1);
      apply_stimulus(1'b0, 4'd0, 1'b1, 1'b0, 2'd2, 2'd0);
      check_output("os_frozen", 0, 0, 1);
      apply_stimulus(1'b1, 4'd7, 1'b1, 1'b1, 2'd2, 2'd2);
      check_output("os_reload", 7, 0, 0);
      apply_stimulus(1'b0, 4'd0, 1'b1, 1'b1, 2'd2, 2'd2);
      check_output("os_resume", 5, 0, 0);

      // Clamped load, lowered limit, zero step.
      apply_stimulus(1'b1, 4'd12, 1'b1, 1'b0, 2'd1, 2'd0);
      check_output("load_clamp", 9, 0, 0);
      lim = 4'd4;
      apply_stimulus(1'b0, 4'd0, 1'b1, 1'b0, 2'd1, 2'd0);
      check_output("lim_lowered", 0, 1, 0);
      apply_stimulus(1'b1, 4'd3, 1'b1, 1'b0, 2'd0, 2'd0);
      check_output("step0_load", 3, 0, 0);
      apply_stimulus(1'b0, 4'd0, 1'b1, 1'b0, 2'd0, 2'd1);
      check_output("step0_hold", 3, 0, 0);

      // Randomized traffic; the every-cycle compare carries the checking.
      lim = 4'd9;
      for (int i = 0; i < 3000; i++) begin
         rst = ($urandom_range(0, 99) == 0);
         if ($urandom_range(0, 19) == 0) lim = 4'($urandom_range(0, 15));
         apply_stimulus(1'($urandom_range(0, 11) == 0), 4'($urandom_range(0, 15)),
                        1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                        2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
      end
      rst = 1'b0;

      @(posedge clk);
      @(negedge clk);
      #1;
      checking = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
